// File: rtl/debounce_sync_if.sv
// Signal bundle for the debouncer: raw input toward the block, debounced level and edge strobes back.
// master drives data_in; slave is the debouncer itself.
interface debounce_sync_if;
  logic data_in;
  logic data;
  logic rise;
  logic fall;
  logic busy;

  modport master (output data_in, input data, rise, fall, busy);
  modport slave  (input data_in, output data, rise, fall, busy);
endinterface

// File: rtl/debounce_sync.sv
// Switch/button debouncer: samples data_in, qualifies a level after STABLE_CYCLES identical samples.
// Optional macro DEBOUNCE_SYNC_EN selects a two-flop synchronizer instead of a single sample register.
//
// state   | meaning
// --------+---------------------------------------------------
// ST_LO   | accepted level 0, no candidate change
// WAIT_HI | candidate 1 being qualified, cnt = samples seen
// ST_HI   | accepted level 1, no candidate change
// WAIT_LO | candidate 0 being qualified, cnt = samples seen
module debounce_sync #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic            clk,
  input  logic            reset,
  debounce_sync_if.slave  bus
);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535 ||
      (longint'(1) << CNT_W) <= longint'(STABLE_CYCLES)) begin : g_bad_param
    $error("debounce_sync: illegal STABLE_CYCLES/CNT_W combination");
  end

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    WAIT_HI = 2'd1,
    ST_HI   = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic smp;

`ifdef DEBOUNCE_SYNC_EN
  logic smp_meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_meta <= 1'b0;
      smp      <= 1'b0;
    end else begin
      smp_meta <= bus.data_in;
      smp      <= smp_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp <= 1'b0;
    end else begin
      smp <= bus.data_in;
    end
  end
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             data_q, data_nxt;
  logic             rise_q, rise_nxt;
  logic             fall_q, fall_nxt;
  logic             busy_q, busy_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_LO;
      cnt    <= '0;
      data_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      data_q <= data_nxt;
      rise_q <= rise_nxt;
      fall_q <= fall_nxt;
      busy_q <= busy_nxt;
    end
  end

  // cnt counts opposite samples seen so far; it is cleared on every exit so it can never wrap
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      ST_LO: begin
        if (smp) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!smp) begin
          state_nxt = ST_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HI;
          cnt_nxt   = '0;
          data_nxt  = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!smp) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (smp) begin
          state_nxt = ST_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LO;
          cnt_nxt   = '0;
          data_nxt  = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_LO;
        cnt_nxt   = '0;
        data_nxt  = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
  end

  assign bus.data = data_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboarded bench for debounce_sync: window-based reference model, directed latency cases, random bounce.
module tb_debounce_sync;
  localparam int S = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  debounce_sync_if bus ();

  debounce_sync #(.STABLE_CYCLES(S), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected {data, rise, fall, busy} per clock edge
  logic [3:0] sbq[$];

  // reference model: sample pipeline plus a window of the last S evaluated samples
  logic m_p1 = 1'b0;
  logic m_p2 = 1'b0;
  logic m_data = 1'b0;
  logic hist[$];

  task automatic model_edge(output logic [3:0] e);
    logic ev, flip, r, f;
    int   run;
    if (!reset) begin
      m_p1 = 1'b0; m_p2 = 1'b0; m_data = 1'b0;
      hist.delete();
      e = 4'b0000;
      return;
    end
    ev   = (LAT == 2) ? m_p2 : m_p1;
    m_p2 = m_p1;
    m_p1 = bus.data_in;
    hist.push_back(ev);
    if (hist.size() > S) void'(hist.pop_front());
    flip = (hist.size() == S);
    for (int i = 0; i < hist.size(); i++)
      if (hist[i] == m_data) flip = 1'b0;
    r = 1'b0; f = 1'b0;
    if (flip) begin
      r = ev; f = ~ev; m_data = ev;
    end
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != m_data) run++;
      else break;
    end
    e = {m_data, r, f, (run > 0)};
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // one clock edge: model the edge, queue the expectation, then drive the next input value
  task automatic step(input logic d);
    logic [3:0] e;
    @(posedge clk);
    #1;
    model_edge(e);
    sbq.push_back(e);
    bus.data_in = d;
  endtask

  always @(negedge clk) begin
    logic [3:0] exp_v, got;
    if (sbq.size() != 0) begin
      exp_v = sbq.pop_front();
      got   = {bus.data, bus.rise, bus.fall, bus.busy};
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL scoreboard t=%0t actual(data,rise,fall,busy)=%b expected=%b", $time, got, exp_v);
      end
    end
  end

  initial begin
    int nr, nf, nb, re, fe, lvl, len, togg;
    logic prev;
    reset       = 1'b0;
    bus.data_in = 1'b1;

    // reset held with input high, then release and qualify the high level
    repeat (3) step(1'b1);
    chk("reset_outputs", int'({bus.data, bus.rise, bus.fall, bus.busy}), 0);
    @(negedge clk); #1 reset = 1'b1;
    nr = 0; re = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1);
      if (bus.rise) begin nr++; if (re == 0) re = k; end
    end
    chk("post_reset_rise_edge", re, S + LAT);
    chk("post_reset_rise_count", nr, 1);
    chk("post_reset_data", int'(bus.data), 1);

    // return to low
    repeat (12) step(1'b0);
    chk("low_level", int'(bus.data), 0);

    // short high pulse of 3 cycles is rejected
    nr = 0; nb = 0;
    for (int k = 0; k < 15; k++) begin
      step(k < 3);
      if (bus.rise) nr++;
      if (bus.busy) nb++;
    end
    chk("short_busy_cycles", nb, 3);
    chk("short_rise_count", nr, 0);
    chk("short_data", int'(bus.data), 0);

    // high 2, low 1, high 20: qualification restarts after the dip
    nr = 0; re = -1;
    for (int k = 0; k < 28; k++) begin
      step(!(k == 2));
      if (bus.rise) begin nr++; if (re < 0) re = k; end
    end
    chk("dip_rise_latency", re - 3, S + LAT);
    chk("dip_rise_count", nr, 1);
    chk("dip_data", int'(bus.data), 1);

    // from high, hold low 10+ cycles
    nf = 0; nb = 0; fe = -1;
    for (int k = 0; k < 15; k++) begin
      step(1'b0);
      if (bus.fall) begin nf++; if (fe < 0) fe = k; end
      if (bus.busy) nb++;
    end
    chk("fall_latency", fe, S + LAT);
    chk("fall_count", nf, 1);
    chk("fall_busy_cycles", nb, 3);
    chk("fall_data", int'(bus.data), 0);

    // reset mid-qualification (cnt=2) aborts; full qualification afterwards
    for (int k = 0; k <= LAT + 2; k++) step(1'b1);
    @(negedge clk); #1;
    chk("pre_abort_busy", int'(bus.busy), 1);
    reset = 1'b0;
    #1;
    chk("abort_outputs", int'({bus.data, bus.rise, bus.fall, bus.busy}), 0);
    repeat (2) step(1'b1);
    @(negedge clk); #1 reset = 1'b1;
    nr = 0; re = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1);
      if (bus.rise) begin nr++; if (re == 0) re = k; end
    end
    chk("abort_restart_rise_edge", re, S + LAT);
    chk("abort_restart_rise_count", nr, 1);

    // bounce with runs of 1..3 never qualifies
    nr = 0; nf = 0; togg = 0; prev = bus.data; lvl = 0;
    for (int c = 0; c < 1000; ) begin
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) begin
        step(lvl[0]);
        if (bus.rise) nr++;
        if (bus.fall) nf++;
        if (bus.data != prev) togg++;
        prev = bus.data;
        c++;
      end
      lvl = lvl ^ 1;
    end
    chk("bounce_rise_count", nr, 0);
    chk("bounce_fall_count", nf, 0);
    chk("bounce_data_toggles", togg, 0);
    chk("bounce_data", int'(bus.data), 1);

    // random runs of 1..8 cycles, checked by the scoreboard
    lvl = 0;
    for (int c = 0; c < 1500; ) begin
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        step(lvl[0]);
        c++;
      end
      lvl = lvl ^ 1;
    end

    repeat (3) step(bus.data_in);
    @(negedge clk); #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required to accept a new level; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: counter width; SHALL satisfy 2^CNT_W > STABLE_CYCLES.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-005 data_in  in  1  raw, asynchronous, bouncing input (switch/button).
REQ-006 data  out  1  debounced registered level; drives the data input of the downstream D flip-flop stage.
REQ-007 rise  out  1  one-cycle pulse when data changes 0->1.
REQ-008 fall  out  1  one-cycle pulse when data changes 1->0.
REQ-009 busy  out  1  high while a candidate level change is being qualified.

Function
REQ-010 data_in SHALL pass through a sampling stage (see Configuration); its output, "smp", is the only value the FSM evaluates.
REQ-011 The FSM SHALL have exactly four states: ST_LO, WAIT_HI, ST_HI, WAIT_LO.
REQ-012 ST_LO: smp=1 -> WAIT_HI, cnt<=1; otherwise remain, cnt<=0.
REQ-013 WAIT_HI: smp=0 -> ST_LO, cnt<=0 (glitch rejected, no output change); smp=1 and cnt=STABLE_CYCLES-1 -> ST_HI, data<=1, rise<=1, cnt<=0; smp=1 otherwise -> cnt<=cnt+1.
REQ-014 ST_HI and WAIT_LO SHALL mirror REQ-012/013 with polarity inverted; qualifying exit from WAIT_LO sets data<=0, fall<=1.
REQ-015 data SHALL change only on the edge that evaluates the STABLE_CYCLES-th consecutive opposite sample; any shorter run leaves data unchanged.
REQ-016 rise and fall SHALL be registered, high for exactly one cycle, never simultaneously high, and low in every cycle in which data does not change.
REQ-017 busy SHALL be a registered decode equal to 1 exactly when the state is WAIT_HI or WAIT_LO.
REQ-018 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL not wrap.
REQ-019 A reverting sample in a WAIT state SHALL restart qualification from zero on the next opposite sample; partial counts are not retained.

Reset
REQ-020 While reset=0: state=ST_LO, cnt=0, data=0, rise=0, fall=0, busy=0, all sampling registers=0.
REQ-021 Reset asserted mid-qualification SHALL abort it without emitting rise or fall.
REQ-022 After reset release with data_in held high, the block SHALL qualify the high level normally and emit one rise pulse.

Configuration
REQ-023 Macro DEBOUNCE_SYNC_EN defined: the sampling stage SHALL be a two-flop synchronizer; latency from a stable data_in change to the data change = STABLE_CYCLES+2 clk edges.
REQ-024 Macro DEBOUNCE_SYNC_EN undefined: the sampling stage SHALL be a single register; latency = STABLE_CYCLES+1 clk edges; all other behaviour is identical.

Verification (STABLE_CYCLES=4; latencies given without / with DEBOUNCE_SYNC_EN)
REQ-025 Hold reset=0 with data_in=1 -> data=rise=fall=busy=0; release reset -> rise pulses for 1 cycle and data=1 at edge 5 / 6 after release.
REQ-026 From ST_LO, drive data_in high for exactly 3 clk cycles, then low -> data stays 0, rise never asserts, busy high for 3 cycles then 0.
REQ-027 data_in pattern high 2, low 1, then high 20 cycles -> data rises 5 / 6 edges after the final low-to-high transition; exactly one rise pulse.
REQ-028 From ST_HI, hold data_in low for 10 cycles -> fall high for exactly 1 cycle, data=0 after edge 5 / 6, busy high for 3 cycles beforehand.
REQ-029 In WAIT_HI with cnt=2, pulse reset low mid-cycle -> outputs clear before the next edge; after release with data_in=1, the full 4-sample qualification restarts.
REQ-030 Random bouncing with run lengths of 1-3 cycles for 1000 cycles -> data never toggles, rise=fall=0 throughout.
